// File: rtl/hdmi_cfg_pkg.sv
// Register table and state encodings for the HDMI transmitter
// configuration sequencer and its I2C write engine.
package hdmi_cfg_pkg;

  localparam int NUM_REGS = 11;

  // 24-bit RGB 4:4:4, HDMI/DVI mode
  localparam logic [7:0] TAB_REG [NUM_REGS] = '{
    8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2,
    8'hA3, 8'hE0, 8'hF9, 8'h15, 8'hAF
  };

  localparam logic [7:0] TAB_DATA [NUM_REGS] = '{
    8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4,
    8'hA4, 8'hD0, 8'h00, 8'h00, 8'h06
  };

  typedef enum logic [2:0] {
    WAIT_PWR, IDLE, LOAD, XFER, NEXT, DONE, ERROR
  } seq_state_t;

  typedef enum logic [2:0] {
    B_IDLE, B_START, B_BIT, B_STOP, B_TAIL
  } bus_state_t;

endpackage

// File: rtl/hdmi_tx_config_seq_i2c.sv
// Single-register I2C write engine: START, three bytes with
// ACK slots, STOP, then a short bus-free gap before done.
module hdmi_i2c_write3
  import hdmi_cfg_pkg::*;
#(
  parameter int QTR = 125
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       cmd,
  input  logic [6:0] dev,
  input  logic [7:0] reg_addr,
  input  logic [7:0] data,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_low,
  output logic       done,
  output logic       ack_ok
);

  bus_state_t  st;
  logic [15:0] div;
  logic [1:0]  q;
  logic [3:0]  bitn;
  logic [1:0]  byten;
  logic [23:0] sh;
  logic        nack;
  logic        tick;

  assign tick = (div == 16'(QTR - 1));

  // SCL is high in quarters 2 and 3 of every bit period
  always_comb begin
    scl = 1'b1;
    unique case (st)
      B_BIT, B_STOP: scl = q[1];
      default: scl = 1'b1;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      st      <= B_IDLE;
      div     <= '0;
      q       <= '0;
      bitn    <= '0;
      byten   <= '0;
      sh      <= '0;
      nack    <= 1'b0;
      sda_low <= 1'b0;
      done    <= 1'b0;
      ack_ok  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st == B_IDLE) begin
        div <= '0;
        q   <= '0;
        if (cmd) begin
          st      <= B_START;
          sh      <= {dev, 1'b0, reg_addr, data};
          bitn    <= '0;
          byten   <= '0;
          nack    <= 1'b0;
          sda_low <= 1'b1;
        end
      end else begin
        div <= tick ? '0 : div + 16'd1;
        if (tick) begin
          q <= q + 2'd1;
          unique case (st)
            B_START: begin
              if (q == 2'd1) begin
                st <= B_BIT;
                q  <= '0;
              end
            end
            B_BIT: begin
              // data moves mid-way through the SCL-low half
              if (q == 2'd0)
                sda_low <= (bitn != 4'd8) && !sh[23];
              if (q == 2'd2 && bitn == 4'd8)
                nack <= sda_in;
              if (q == 2'd3) begin
                if (bitn != 4'd8) begin
                  sh   <= {sh[22:0], 1'b0};
                  bitn <= bitn + 4'd1;
                end else if (nack || byten == 2'd2) begin
                  st <= B_STOP;
                end else begin
                  byten <= byten + 2'd1;
                  bitn  <= '0;
                end
              end
            end
            B_STOP: begin
              if (q == 2'd0) sda_low <= 1'b1;
              if (q == 2'd2) sda_low <= 1'b0;
              if (q == 2'd3) st <= B_TAIL;
            end
            B_TAIL: begin
              if (q == 2'd3) begin
                st     <= B_IDLE;
                done   <= 1'b1;
                ack_ok <= !nack;
              end
            end
            default: st <= B_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/hdmi_tx_config_seq.sv
// Power-up / hot-plug sequencer that writes the transmitter
// register table over I2C and reports done or error.
module hdmi_tx_config_seq
  import hdmi_cfg_pkg::*;
#(
  parameter int         CLK_HZ    = 50000000,
  parameter int         I2C_HZ    = 100000,
  parameter logic [6:0] DEV_ADDR  = 7'h39,
  parameter int         PWR_WAIT  = 10000000,
  parameter int         RETRY_MAX = 3
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       start,
  input  logic       hpd,
  output logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       busy,
  output logic       config_done,
  output logic       config_error,
  output logic [3:0] err_index
);

  localparam int QTR = CLK_HZ / (4 * I2C_HZ);
  localparam int WW  = $clog2(PWR_WAIT + 1);
  localparam int RW  = $clog2(RETRY_MAX + 1);

  seq_state_t    state, nxt;
  logic [WW-1:0] wcnt;
  logic [3:0]    idx;
  logic [RW-1:0] retry;
  logic          pending;
  logic          hs0, hs1, hs2;
  logic          rise, fall, req;
  logic          cmd, reissue;
  logic          eng_done, eng_ack, sda_low;

  assign rise = hs1 & ~hs2;
  assign fall = ~hs1 & hs2;
  assign req  = start | rise;
  assign busy = (state == LOAD) || (state == XFER)
             || (state == NEXT);

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

  always_comb begin
    nxt     = state;
    cmd     = 1'b0;
    reissue = 1'b0;
    unique case (state)
      WAIT_PWR: if (wcnt == WW'(PWR_WAIT - 1)) nxt = LOAD;
      IDLE:     if (req) nxt = LOAD;
      LOAD: begin
        cmd = 1'b1;
        nxt = XFER;
      end
      XFER: begin
        if (eng_done) begin
          if (eng_ack) begin
            nxt = NEXT;
          end else if (retry < RW'(RETRY_MAX)) begin
            cmd     = 1'b1;
            reissue = 1'b1;
          end else begin
            nxt = ERROR;
          end
        end
      end
      NEXT: nxt = (idx == 4'(NUM_REGS - 1)) ? DONE : LOAD;
      DONE, ERROR: nxt = (req || pending) ? LOAD : IDLE;
      default: nxt = WAIT_PWR;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      state        <= WAIT_PWR;
      wcnt         <= '0;
      idx          <= '0;
      retry        <= '0;
      pending      <= 1'b0;
      hs0          <= 1'b0;
      hs1          <= 1'b0;
      hs2          <= 1'b0;
      config_done  <= 1'b0;
      config_error <= 1'b0;
      err_index    <= '0;
    end else begin
      state <= nxt;
      hs0   <= hpd;
      hs1   <= hs0;
      hs2   <= hs1;
      if (state == WAIT_PWR) wcnt <= wcnt + 1'b1;
      if (state == LOAD) retry <= '0;
      if (reissue) retry <= retry + 1'b1;
      if (state == NEXT && nxt == LOAD) idx <= idx + 4'd1;
      // the first pass after power-up already serves early requests
      if (busy && req) pending <= 1'b1;
      if (nxt == LOAD && !busy) begin
        idx          <= '0;
        pending      <= 1'b0;
        config_done  <= 1'b0;
        config_error <= 1'b0;
      end
      if (state == DONE && nxt == IDLE) config_done <= 1'b1;
      if (state == ERROR) begin
        err_index    <= idx;
        config_error <= (nxt == IDLE);
      end
      if (fall) config_done <= 1'b0;
    end
  end

  hdmi_i2c_write3 #(.QTR(QTR)) u_eng (
    .clock_50 (clock_50),
    .reset    (reset),
    .cmd      (cmd),
    .dev      (DEV_ADDR),
    .reg_addr (TAB_REG[idx]),
    .data     (TAB_DATA[idx]),
    .sda_in   (i2c_sda),
    .scl      (i2c_scl),
    .sda_low  (sda_low),
    .done     (eng_done),
    .ack_ok   (eng_ack)
  );

endmodule
